issue_station: RTL
==================

ISSUE_STATION -- requirements
Module: issue_station

Interface
REQ-001 Parameters (name, default, meaning), one per line:
 ROB_ENTRY, 4, ROB entries; ROB_W = clog2(ROB_ENTRY)
 DATA_WIDTH, 32, operand/immediate width
 RS_DEPTH, 4, station entries (>=2); CNT_W = clog2(RS_DEPTH+1)
 FU_NUM, 4, function units; FUNC_W = clog2(FU_NUM)
 OPR_W, 4, operator field width
 OPD_W, 2, operand-select field width
 CDB_PORTS, 2, common data bus broadcast ports
REQ-002 Ports (name, direction, width, meaning), one per line:
 CLK  in  1  single clock, rising edge
 RSTN  in  1  asynchronous active-low reset
 flush  in  1  discard all entries
 in_valid  in  1  renamed instruction offered
 in_ready  out  1  station can accept
 in_function  in  FUNC_W  target FU
 in_operator  in  OPR_W  operator
 in_oprand  in  OPD_W  operand select
 in_imm  in  DATA_WIDTH  immediate
 in_rob_entry  in  ROB_W  allocated ROB tag
 in_rs1_busy / in_rs2_busy  in  1  operand pending on ROB tag
 in_rs1_alias / in_rs2_alias  in  ROB_W  producer tag
 in_rs1_data / in_rs2_data  in  DATA_WIDTH  value when not busy
 cdb_valid  in  CDB_PORTS  broadcast valid per port
 cdb_id  in  CDB_PORTS*ROB_W  broadcast tags, port p at [p*ROB_W+:ROB_W]
 cdb_data  in  CDB_PORTS*DATA_WIDTH  broadcast values
 fu_wok  in  FU_NUM  FU f can accept this cycle
 isr_valid  out  1  instruction issued this cycle
 isr_function, isr_operator, isr_oprand, isr_imm, isr_rob_entry  out  as in_*  issued fields
 isr_rs1_data / isr_rs2_data  out  DATA_WIDTH  resolved operands
 occupancy  out  CNT_W  valid entry count

Function
REQ-003 Storage SHALL be a collapsing queue: entry 0 oldest; valid entries contiguous from 0.
REQ-004 Insert SHALL occur when in_valid & in_ready & ~flush; in_ready = (occupancy < RS_DEPTH), registered-state only, no combinational path from fu_wok.
REQ-005 Entry ready = valid & ~rs1_busy & ~rs2_busy & fu_wok[function].
REQ-006 Select SHALL be lowest-index ready entry; isr_valid = any ready & ~flush; isr_* driven combinationally from selected entry; issue is the handshake (no isr ready input).
REQ-007 On issue of entry k, entries k+1.. SHALL shift down one slot same edge; occupancy decrements.
REQ-008 Simultaneous insert and issue: new entry written to slot occupancy-1 after shift; occupancy unchanged.
REQ-009 Wakeup: each cycle, every valid busy operand whose alias equals cdb_id[p] with cdb_valid[p] SHALL capture cdb_data[p] and clear busy; lowest p wins on multi-match.
REQ-010 Insert bypass: an incoming busy operand matching a same-cycle CDB broadcast SHALL be stored not busy with CDB data.
REQ-011 Latency: inserted at edge T -> issuable in cycle after T; wakeup captured at edge T -> issuable in cycle after T; no same-cycle CDB-to-issue forward.
REQ-012 Wakeup SHALL apply to entries in the same edge they shift (shifted entry keeps captured value).
REQ-013 flush SHALL clear all valid bits at next edge, block insert and issue that cycle; occupancy 0 next cycle.
REQ-014 Outputs for invalid/unselected state: isr_* fields SHALL be 0 when isr_valid=0.

Reset
REQ-015 RSTN low SHALL asynchronously clear all entry valid, busy, data and field registers; occupancy=0, in_ready=1, isr_valid=0, all isr_* = 0.
REQ-016 Reset asserted mid-operation SHALL discard all entries with no issue on release edge.

Verification
REQ-017 Insert ALU op, both not busy, fu_wok=4'b1111 -> isr_valid=1 next cycle, occupancy 1->0.
REQ-018 Insert rs1_busy alias=2; next cycle cdb_valid=01, cdb_id=2, data=0xDEAD -> issue following cycle with isr_rs1_data=0xDEAD.
REQ-019 Insert busy alias=3 while cdb port1 broadcasts tag 3 data=0x55 same cycle -> stored ready, issues next cycle with 0x55.
REQ-020 Fill 4 entries (entry0 LSU, lsu fu_wok=0; entries1-3 ALU ready) -> issue order 1,2,3, entry0 remains at slot0, in_ready=0 while occupancy=4.
REQ-021 occupancy=3, issue and insert same cycle -> occupancy stays 3, new entry at slot2; then flush -> occupancy=0, isr_valid=0 that cycle.
REQ-022 RSTN pulsed low with 3 entries -> occupancy=0, in_ready=1 immediately, no isr_valid after release.

Source files
------------

// File: rtl/issue_station.sv
// Collapsing-queue reservation station: oldest-first select of ready entries,
// CDB wakeup on stored and incoming operands, shift-down on issue.
module issue_station #(
   parameter int ROB_ENTRY  = 4,
   parameter int DATA_WIDTH = 32,
   parameter int RS_DEPTH   = 4,
   parameter int FU_NUM     = 4,
   parameter int OPR_W      = 4,
   parameter int OPD_W      = 2,
   parameter int CDB_PORTS  = 2,
   localparam int ROB_W  = (ROB_ENTRY > 1) ? $clog2(ROB_ENTRY) : 1,
   localparam int CNT_W  = $clog2(RS_DEPTH + 1),
   localparam int FUNC_W = (FU_NUM > 1) ? $clog2(FU_NUM) : 1
) (
   input  logic                          CLK,
   input  logic                          RSTN,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [FUNC_W-1:0]             in_function,
   input  logic [OPR_W-1:0]              in_operator,
   input  logic [OPD_W-1:0]              in_oprand,
   input  logic [DATA_WIDTH-1:0]         in_imm,
   input  logic [ROB_W-1:0]              in_rob_entry,
   input  logic                          in_rs1_busy,
   input  logic                          in_rs2_busy,
   input  logic [ROB_W-1:0]              in_rs1_alias,
   input  logic [ROB_W-1:0]              in_rs2_alias,
   input  logic [DATA_WIDTH-1:0]         in_rs1_data,
   input  logic [DATA_WIDTH-1:0]         in_rs2_data,
   input  logic [CDB_PORTS-1:0]          cdb_valid,
   input  logic [CDB_PORTS*ROB_W-1:0]    cdb_id,
   input  logic [CDB_PORTS*DATA_WIDTH-1:0] cdb_data,
   input  logic [FU_NUM-1:0]             fu_wok,
   output logic                          isr_valid,
   output logic [FUNC_W-1:0]             isr_function,
   output logic [OPR_W-1:0]              isr_operator,
   output logic [OPD_W-1:0]              isr_oprand,
   output logic [DATA_WIDTH-1:0]         isr_imm,
   output logic [ROB_W-1:0]              isr_rob_entry,
   output logic [DATA_WIDTH-1:0]         isr_rs1_data,
   output logic [DATA_WIDTH-1:0]         isr_rs2_data,
   output logic [CNT_W-1:0]              occupancy
);

   typedef struct packed {
      logic                  b1;
      logic                  b2;
      logic [ROB_W-1:0]      a1;
      logic [ROB_W-1:0]      a2;
      logic [DATA_WIDTH-1:0] d1;
      logic [DATA_WIDTH-1:0] d2;
      logic [FUNC_W-1:0]     fn;
      logic [OPR_W-1:0]      op;
      logic [OPD_W-1:0]      opd;
      logic [DATA_WIDTH-1:0] imm;
      logic [ROB_W-1:0]      rob;
   } ent_t;

   ent_t                ent_q [RS_DEPTH];
   ent_t                ent_d [RS_DEPTH];
   ent_t                wk    [RS_DEPTH+1];
   ent_t                nw;
   logic [RS_DEPTH-1:0] vld_q, vld_d, rdy;
   logic [CNT_W-1:0]    cnt_q, cnt_d, sel, wr_slot;
   logic                any_rdy, issue, ins;

   assign in_ready  = (cnt_q < CNT_W'(RS_DEPTH));
   assign occupancy = cnt_q;

   // Wakeup of stored entries; descending port loop lets the lowest port win.
   always_comb begin
      for (int j = 0; j < RS_DEPTH; j++) begin
         wk[j] = ent_q[j];
         for (int p = CDB_PORTS-1; p >= 0; p--) begin
            if (cdb_valid[p] && ent_q[j].b1 && ent_q[j].a1 == cdb_id[p*ROB_W +: ROB_W]) begin
               wk[j].b1 = 1'b0;
               wk[j].d1 = cdb_data[p*DATA_WIDTH +: DATA_WIDTH];
            end
            if (cdb_valid[p] && ent_q[j].b2 && ent_q[j].a2 == cdb_id[p*ROB_W +: ROB_W]) begin
               wk[j].b2 = 1'b0;
               wk[j].d2 = cdb_data[p*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
      wk[RS_DEPTH] = '0;
   end

   always_comb begin
      nw.b1  = in_rs1_busy;
      nw.b2  = in_rs2_busy;
      nw.a1  = in_rs1_alias;
      nw.a2  = in_rs2_alias;
      nw.d1  = in_rs1_data;
      nw.d2  = in_rs2_data;
      nw.fn  = in_function;
      nw.op  = in_operator;
      nw.opd = in_oprand;
      nw.imm = in_imm;
      nw.rob = in_rob_entry;
      for (int p = CDB_PORTS-1; p >= 0; p--) begin
         if (cdb_valid[p] && in_rs1_busy && in_rs1_alias == cdb_id[p*ROB_W +: ROB_W]) begin
            nw.b1 = 1'b0;
            nw.d1 = cdb_data[p*DATA_WIDTH +: DATA_WIDTH];
         end
         if (cdb_valid[p] && in_rs2_busy && in_rs2_alias == cdb_id[p*ROB_W +: ROB_W]) begin
            nw.b2 = 1'b0;
            nw.d2 = cdb_data[p*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      any_rdy = 1'b0;
      sel     = '0;
      for (int j = RS_DEPTH-1; j >= 0; j--) begin
         rdy[j] = vld_q[j] & ~ent_q[j].b1 & ~ent_q[j].b2 & fu_wok[ent_q[j].fn];
         if (rdy[j]) begin
            any_rdy = 1'b1;
            sel     = CNT_W'(j);
         end
      end
   end

   assign issue   = any_rdy & ~flush;
   assign ins     = in_valid & in_ready & ~flush;
   assign wr_slot = issue ? cnt_q - CNT_W'(1) : cnt_q;
   assign cnt_d   = flush ? '0 : cnt_q + CNT_W'(ins) - CNT_W'(issue);

   // Collapse above the issued slot, then drop the new entry at the tail.
   always_comb begin
      for (int j = 0; j < RS_DEPTH; j++) begin
         ent_d[j] = (issue && CNT_W'(j) >= sel) ? wk[j+1] : wk[j];
         if (ins && CNT_W'(j) == wr_slot) ent_d[j] = nw;
         vld_d[j] = (CNT_W'(j) < cnt_d);
      end
   end

   always_comb begin
      isr_valid     = issue;
      isr_function  = '0;
      isr_operator  = '0;
      isr_oprand    = '0;
      isr_imm       = '0;
      isr_rob_entry = '0;
      isr_rs1_data  = '0;
      isr_rs2_data  = '0;
      for (int j = 0; j < RS_DEPTH; j++) begin
         if (issue && CNT_W'(j) == sel) begin
            isr_function  = ent_q[j].fn;
            isr_operator  = ent_q[j].op;
            isr_oprand    = ent_q[j].opd;
            isr_imm       = ent_q[j].imm;
            isr_rob_entry = ent_q[j].rob;
            isr_rs1_data  = ent_q[j].d1;
            isr_rs2_data  = ent_q[j].d2;
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         cnt_q <= '0;
         vld_q <= '0;
         for (int j = 0; j < RS_DEPTH; j++) ent_q[j] <= '0;
      end else begin
         cnt_q <= cnt_d;
         vld_q <= vld_d;
         for (int j = 0; j < RS_DEPTH; j++) ent_q[j] <= ent_d[j];
      end
   end

endmodule
